vx_perf_snapshot_ctrl: RTL and testbench
========================================

// Module: vx_perf_snapshot_ctrl
// PURPOSE
//  Sequences readout of the pipeline performance counters (sched/ibf/nocu stalls, rf reads/writes,
//  reorders, reorder distances, cu/rrs util, fetch/load/store counts and latencies).
//  On request it captures a selected range of counters into a shadow bank in one cycle.
//  It then streams the range out as OUT_W-bit words over a valid/ready port, lowest counter and
//  word first. Sits between the per-core perf interface and the CSR/DCR readout path.
// PARAMETERS
//  NUM_CTRS  24  counters on the flattened input bus (range 1..256)
//  CTR_W     44  width of each counter (PERF_CTR_BITS); 64 for alloc-period counters
//  OUT_W     32  output word width; WPC = ceil(CTR_W/OUT_W) words per counter
//  ID_W      $clog2(NUM_CTRS) (min 1)  counter index width (localparam-derived)
// PORTS
//  clk        in   1                 clock
//  reset_n    in   1                 asynchronous active-low reset
//  ctrs_in    in   NUM_CTRS*CTR_W    live counters; counter i = ctrs_in[i*CTR_W +: CTR_W]
//  snap_req   in   1                 request snapshot+stream (level, sampled in IDLE only)
//  snap_first in   ID_W              first counter index of range
//  snap_count in   ID_W+1            number of counters in range
//  abort      in   1                 terminate any in-progress operation
//  snap_ack   out  1                 1-cycle pulse: capture performed this cycle
//  snap_err   out  1                 1-cycle pulse: request rejected (bad range)
//  busy       out  1                 high in CAPTURE and STREAM
//  out_valid  out  1                 word available
//  out_ready  in   1                 consumer accepts word
//  out_data   out  OUT_W             word; zero-extended above CTR_W; 0 when !out_valid
//  out_idx    out  ID_W              counter index of current word
//  out_wsel   out  $clog2(WPC) (min 1)  word number within counter, 0 = least significant
//  out_last   out  1                 current word is the final word of the range
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; index/word counters 0. Shadow bank is not reset (never
//    visible: out_data is gated by out_valid).
//  FSM IDLE -> CAPTURE -> STREAM -> IDLE. abort in any state forces IDLE next cycle.
//  IDLE: snap_req=1 with snap_count!=0 and snap_first+snap_count<=NUM_CTRS (ID_W+2-bit compare,
//    no wrap) -> latch first/count, go to CAPTURE. Otherwise with snap_req=1 -> snap_err=1 next
//    cycle, stay IDLE.
//  CAPTURE (exactly 1 cycle): snap_ack=1, busy=1. Shadow[i] <= ctrs_in[i] for all i at the end of
//    this cycle (coherent single-edge sample). Next state is STREAM.
//  STREAM: out_valid=1; out_data = word out_wsel of shadow[out_idx].
//    Handshake = out_valid & out_ready. Without a handshake, out_data/out_idx/out_wsel/out_last
//    hold stable. On a handshake, wsel increments. At wsel=WPC-1, wsel->0 and idx increments.
//  out_last = (idx==first+count-1) & (wsel==WPC-1). Handshake on out_last -> IDLE. busy and
//    out_valid are 0 the next cycle.
//  Latency: snap_req accepted at cycle T -> snap_ack at T+1 -> first out_valid at T+2. Best
//    case: range done after count*WPC cycles. The earliest next acceptance is the cycle after
//    the last handshake.
//  snap_req while busy: ignored, no ack, no err. A new request is sampled only after returning
//    to IDLE.
//  abort during STREAM: out_valid drops the next cycle with no out_last. This is the only
//    permitted break of valid stability. abort and a handshake in the same cycle: the word
//    counts as consumed and the block still goes IDLE. abort in IDLE: no effect.
//  reset_n low mid-operation: immediate return to the reset state. No ack/err pulses.
//  Range edge cases: count=NUM_CTRS with first=0 is legal. count=1 gives WPC words.
// TESTING
//  1 Defaults; ctr[i]=0xA_0000_0000+i; first=0,count=2 -> words 0x00000000,0x0A,0x00000001,0x0A;
//    out_last on word 4; ack at T+1, valid at T+2.
//  2 Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data/out_idx/out_wsel unchanged;
//    no word lost or repeated.
//  3 Coherence: increment all ctrs_in every cycle after ack -> streamed values equal the
//    CAPTURE-cycle values.
//  4 Bad range: first=23,count=2 and first=0,count=0 -> snap_err pulse, no ack, busy=0.
//    first=23,count=1 is accepted.
//  5 Abort at 3rd word of count=4 -> out_valid=0 next cycle, IDLE. A new request is then
//    accepted normally.
//  6 reset_n asserted mid-STREAM (async, between edges) -> outputs 0 immediately.
//    snap_req after release -> full correct dump; repeat with snap_req held while busy -> no
//    extra ack.

Source files
------------

// File: rtl/vx_perf_snapshot_ctrl.sv
// Performance-counter snapshot sequencer: coherent one-cycle capture of a counter range into a
// shadow bank, then streamed out as OUT_W-bit words over valid/ready, lowest counter/word first.
module vx_perf_snapshot_ctrl #(
    parameter  int unsigned NUM_CTRS = 24,
    parameter  int unsigned CTR_W    = 44,
    parameter  int unsigned OUT_W    = 32,
    localparam int unsigned ID_W     = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1,
    localparam int unsigned WPC      = (CTR_W + OUT_W - 1) / OUT_W,
    localparam int unsigned WSEL_W   = (WPC > 1) ? $clog2(WPC) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CTRS*CTR_W-1:0] ctrs_in,
    input  logic                      snap_req,
    input  logic [ID_W-1:0]           snap_first,
    input  logic [ID_W:0]             snap_count,
    input  logic                      abort,
    output logic                      snap_ack,
    output logic                      snap_err,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [ID_W-1:0]           out_idx,
    output logic [WSEL_W-1:0]         out_wsel,
    output logic                      out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     idx_q;
    logic [ID_W-1:0]     last_idx_q;
    logic [WSEL_W-1:0]   wsel_q;
    logic [CTR_W-1:0]    shadow [NUM_CTRS];
    logic [ID_W+1:0]     range_end;
    logic                range_ok;
    logic                accept;
    logic                handshake;
    logic                wsel_end;
    logic [WPC*OUT_W-1:0] padded;

    // Widened so first+count cannot wrap before the bound check.
    assign range_end = (ID_W+2)'(snap_first) + (ID_W+2)'(snap_count);
    assign range_ok  = (snap_count != '0) && (range_end <= (ID_W+2)'(NUM_CTRS));
    assign accept    = (state_q == S_IDLE) && snap_req && range_ok;
    assign handshake = (state_q == S_STREAM) && out_ready;
    assign wsel_end  = (wsel_q == WSEL_W'(WPC - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_CAPTURE;
            S_CAPTURE: state_d = abort ? S_IDLE : S_STREAM;
            S_STREAM:  if (abort || (handshake && out_last)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wsel_q     <= '0;
            last_idx_q <= '0;
            snap_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_err <= (state_q == S_IDLE) && snap_req && !range_ok;
            if (accept) begin
                idx_q      <= snap_first;
                wsel_q     <= '0;
                last_idx_q <= ID_W'(range_end - 1'b1);
            end else if (state_d == S_IDLE) begin
                idx_q  <= '0;
                wsel_q <= '0;
            end else if (handshake) begin
                if (wsel_end) begin
                    wsel_q <= '0;
                    idx_q  <= idx_q + 1'b1;
                end else begin
                    wsel_q <= wsel_q + 1'b1;
                end
            end
        end
    end

    // Shadow bank is never observable outside STREAM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE) begin
            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= ctrs_in[i*CTR_W +: CTR_W];
            end
        end
    end

    always_comb begin
        padded            = '0;
        padded[CTR_W-1:0] = shadow[idx_q];
        out_data          = '0;
        if (state_q == S_STREAM) out_data = padded[wsel_q*OUT_W +: OUT_W];
    end

    assign snap_ack  = (state_q == S_CAPTURE);
    assign busy      = (state_q == S_CAPTURE) || (state_q == S_STREAM);
    assign out_valid = (state_q == S_STREAM);
    assign out_idx   = idx_q;
    assign out_wsel  = wsel_q;
    assign out_last  = (state_q == S_STREAM) && (idx_q == last_idx_q) && wsel_end;

endmodule

// File: tb/tb_vx_perf_snapshot_ctrl.sv
// Self-checking bench for vx_perf_snapshot_ctrl: range table, directed corner sequences and
// randomized dumps checked against a word-queue model built from the captured counter values.
module tb_vx_perf_snapshot_ctrl;

    localparam int NUM = 24;
    localparam int CW  = 44;
    localparam int OW  = 32;
    localparam int IDW = 5;
    localparam int WPC = 2;
    localparam int WSW = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM*CW-1:0] ctrs_in;
    logic              snap_req;
    logic [IDW-1:0]    snap_first;
    logic [IDW:0]      snap_count;
    logic              abort;
    logic              snap_ack;
    logic              snap_err;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [IDW-1:0]    out_idx;
    logic [WSW-1:0]    out_wsel;
    logic              out_last;

    logic [CW-1:0] ctr [NUM];

    typedef struct {
        logic [OW-1:0] data;
        int            idx;
        int            wsel;
    } word_t;

    typedef struct {
        int first;
        int count;
        bit ok;
    } range_vec_t;

    word_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    vx_perf_snapshot_ctrl #(.NUM_CTRS(NUM), .CTR_W(CW), .OUT_W(OW)) dut (
        .clk(clk), .reset_n(reset_n), .ctrs_in(ctrs_in), .snap_req(snap_req),
        .snap_first(snap_first), .snap_count(snap_count), .abort(abort),
        .snap_ack(snap_ack), .snap_err(snap_err), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_wsel(out_wsel),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        ctrs_in = '0;
        for (int i = 0; i < NUM; i++) ctrs_in[i*CW +: CW] = ctr[i];
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request a range, then follow the stream word by word against the model queue.
    // mode: 0 always ready, 1 random ready, 2 five-cycle stall on the third word.
    task automatic dump(input int first, input int count, input int mode, input bit bump,
                        input bit hold, input int abort_at, input int rst_at);
        int consumed = 0;
        int budget   = 0;
        int stall    = 0;
        word_t e;
        logic [63:0] v;
        @(negedge clk);
        snap_req = 1'b1; snap_first = IDW'(first); snap_count = (IDW+1)'(count); out_ready = 1'b0;
        @(negedge clk);
        chk("ack", snap_ack, 1); chk("err_on_ok", snap_err, 0);
        chk("busy_cap", busy, 1); chk("valid_cap", out_valid, 0);
        if (!hold) snap_req = 1'b0;
        exp_q.delete();
        for (int i = first; i < first + count; i++) begin
            for (int w = 0; w < WPC; w++) begin
                v = 64'(ctr[i]);
                e.data = OW'(v >> (OW * w));
                e.idx  = i;
                e.wsel = w;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("valid", out_valid, 1);
            chk("data", out_data, e.data);
            chk("idx", out_idx, e.idx);
            chk("wsel", out_wsel, e.wsel);
            chk("last", out_last, exp_q.size() == 1);
            chk("ack_stream", snap_ack, 0);
            chk("err_stream", snap_err, 0);
            if (consumed == abort_at) begin
                abort = 1'b1; out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                abort = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
                chk("abort_valid", out_valid, 0); chk("abort_busy", busy, 0);
                chk("abort_last", out_last, 0);
                return;
            end
            if (consumed == rst_at) begin
                out_ready = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0);
                chk("rst_data", out_data, 0); chk("rst_idx", out_idx, 0);
                chk("rst_wsel", out_wsel, 0); chk("rst_last", out_last, 0);
                @(negedge clk);
                chk("rst_ack", snap_ack, 0); chk("rst_err", snap_err, 0);
                reset_n = 1'b1; snap_req = 1'b0;
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = !(consumed == 2 && stall < 5);
                    if (!out_ready) stall++;
                end
            endcase
            if (out_ready) begin
                void'(exp_q.pop_front());
                consumed++;
            end
            if (bump) for (int i = 0; i < NUM; i++) ctr[i] = ctr[i] + 1'b1;
            budget++;
            if (budget > 2000) begin
                vectors++; miscompares++;
                $display("FAIL stream_budget: got %0d words left expected 0", exp_q.size());
                break;
            end
            @(negedge clk);
        end
        snap_req = 1'b0; out_ready = 1'b0;
        chk("end_valid", out_valid, 0); chk("end_busy", busy, 0); chk("end_last", out_last, 0);
    endtask

    range_vec_t rtab[9];

    initial begin
        reset_n = 1'b0; snap_req = 1'b0; snap_first = '0; snap_count = '0;
        abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NUM; i++) ctr[i] = 44'hA_0000_0000 + 44'(i);
        repeat (2) @(negedge clk);
        chk("rst_ack0", snap_ack, 0); chk("rst_err0", snap_err, 0); chk("rst_busy0", busy, 0);
        chk("rst_valid0", out_valid, 0); chk("rst_data0", out_data, 0);
        chk("rst_idx0", out_idx, 0); chk("rst_wsel0", out_wsel, 0); chk("rst_last0", out_last, 0);
        reset_n = 1'b1;

        dump(0, 2, 0, 1'b0, 1'b0, -1, -1);
        dump(0, 3, 2, 1'b0, 1'b0, -1, -1);
        dump(0, NUM, 1, 1'b1, 1'b0, -1, -1);

        rtab = '{'{23, 2, 1'b0}, '{0, 0, 1'b0}, '{23, 1, 1'b1}, '{0, 24, 1'b1}, '{1, 24, 1'b0},
                 '{31, 1, 1'b0}, '{5, 0, 1'b0}, '{10, 14, 1'b1}, '{10, 15, 1'b0}};
        for (int k = 0; k < 9; k++) begin
            if (rtab[k].ok) begin
                dump(rtab[k].first, rtab[k].count, 0, 1'b0, 1'b0, -1, -1);
            end else begin
                @(negedge clk);
                snap_req = 1'b1; snap_first = IDW'(rtab[k].first);
                snap_count = (IDW+1)'(rtab[k].count);
                @(negedge clk);
                snap_req = 1'b0;
                chk("bad_err", snap_err, 1); chk("bad_ack", snap_ack, 0); chk("bad_busy", busy, 0);
                @(negedge clk);
                chk("bad_err_pulse", snap_err, 0); chk("bad_busy2", busy, 0);
            end
        end

        dump(4, 4, 0, 1'b0, 1'b0, 2, -1);
        dump(4, 4, 0, 1'b0, 1'b0, -1, -1);
        dump(2, 5, 0, 1'b0, 1'b0, -1, 3);
        dump(0, NUM, 1, 1'b0, 1'b0, -1, -1);
        dump(3, 3, 1, 1'b0, 1'b1, -1, -1);

        for (int n = 0; n < 20; n++) begin
            int f;
            for (int i = 0; i < NUM; i++) ctr[i] = {12'($urandom()), $urandom()};
            f = $urandom_range(0, NUM - 1);
            dump(f, $urandom_range(1, NUM - f), 1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
